mdu_issue_scheduler: RTL and testbench
======================================

// Module: mdu_issue_scheduler
// PURPOSE
//   Sequences the multi-cycle MultiplicationDivisionUnit from the execute stage.
//   Takes the decoded mduUse/mduStart/mduOperation control signals and issues a
//   one-shot start to the MDU. Tracks MDU occupancy with a down-counter and raises
//   a pipeline stall request for any later MDU instruction (start, MFHI/MFLO,
//   MTHI/MTLO) while a multiply or divide is in flight.
// PARAMETERS
//   MUL_LATENCY  5   busy cycles for MDU_START_SIGNED_MUL / MDU_START_UNSIGNED_MUL (>=1)
//   DIV_LATENCY  10  busy cycles for MDU_START_SIGNED_DIV / MDU_START_UNSIGNED_DIV (>=1)
//   CNT_WIDTH    4   counter width; must hold max(MUL_LATENCY,DIV_LATENCY)-1
// PORTS
//   clock         in   1  single clock, rising edge
//   reset         in   1  asynchronous, active-low
//   valid         in   1  execute stage holds a real (non-bubble) instruction
//   advance       in   1  execute-stage instruction moves to memory stage at this edge
//   mduUse        in   1  control signal: instruction uses the MDU
//   mduStart      in   1  control signal: instruction starts a mul/div
//   mduOperation  in   mdu_operation_t  selects the mul or div latency
//   mduIssue      out  1  comb: start strobe to MDU, this cycle only
//   busy          out  1  reg: mul/div in flight
//   busyIsDiv     out  1  reg: in-flight op is a divide (0 when idle)
//   done          out  1  reg: 1-cycle pulse, first cycle after busy falls
//   stallRequest  out  1  comb: hold fetch/decode/execute this cycle
// BEHAVIOUR
//   - FSM states: IDLE, MUL_BUSY, DIV_BUSY. Registers: state, cnt[CNT_WIDTH],
//     issued (current E instruction already issued), done.
//   - Reset (async, any time incl. mid-operation): state=IDLE, cnt=0, issued=0,
//     done=0. Hence busy=0, busyIsDiv=0, done=0, and mduIssue/stallRequest=0
//     while reset is low. A running MDU op is abandoned.
//   - busy = (state!=IDLE); busyIsDiv = (state==DIV_BUSY).
//   - mduIssue = valid & mduStart & !busy & !issued.
//   - stallRequest = valid & mduUse & busy & !issued. The instruction that issued
//     never stalls on its own occupancy.
//   - Issue edge: state <= MUL_BUSY or DIV_BUSY per mduOperation;
//     cnt <= LATENCY-1. mduStart with a non-start mduOperation is treated as MUL.
//   - In *_BUSY: cnt==0 -> state<=IDLE and done<=1; else cnt<=cnt-1.
//     done<=0 on every other edge.
//   - Timing: issue in cycle 0 -> busy=1 in cycles 1..L -> done=1 and busy=0 in
//     cycle L+1. A new issue is legal in cycle L+1 (same cycle as done).
//   - issued: set on issue edge when advance=0; cleared on any edge with
//     advance=1. The issue cycle with advance=1 leaves issued=0.
//     Prevents double issue while E is held by an unrelated stall.
//   - valid=0 (bubble/flush) suppresses mduIssue and stallRequest but does not
//     abort a running op. The counter keeps running regardless of advance or
//     stallRequest.
//   - Issue and completion never coincide (issue requires !busy), so there is no
//     conflicting simultaneous transition.
// TESTING
//   1 MULT valid=1 advance=1 from IDLE -> mduIssue=1 cycle 0; busy=1, busyIsDiv=0
//     cycles 1-5; done=1 cycle 6 only.
//   2 DIV at cycle 0, then MFLO in E from cycle 1 -> stallRequest=1 cycles 1-10,
//     0 in cycle 11 with done=1; no second mduIssue.
//   3 MULTU with advance=0 for 3 cycles -> exactly one mduIssue; stallRequest=0
//     throughout; issued=1 until advance=1.
//   4 Back-to-back MULT, MULT -> second stalls cycles 1-5, issues in cycle 6
//     (done=1 same cycle), busy again cycles 7-11.
//   5 Async reset pulsed low mid-DIV (cycle 4) -> busy, done, busyIsDiv, cnt all 0
//     immediately; after release, MTHI does not stall.
//   6 valid=0 with mduStart=1 -> mduIssue=0, stallRequest=0, state stays IDLE.

Source files
------------

// File: rtl/mdu_issue_scheduler_if.sv
// Shared MDU types and the execute-stage <-> issue-scheduler interface.
// Handshake: mdu_issue is a single-cycle start strobe; stall_request holds E until busy clears.
package mdu_issue_scheduler_pkg;
  typedef enum logic [3:0] {
    MDU_NONE,
    MDU_MFHI,
    MDU_MFLO,
    MDU_MTHI,
    MDU_MTLO,
    MDU_START_SIGNED_MUL,
    MDU_START_UNSIGNED_MUL,
    MDU_START_SIGNED_DIV,
    MDU_START_UNSIGNED_DIV
  } mdu_operation_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    DIV_BUSY
  } sched_state_t;
endpackage

interface mdu_issue_scheduler_if;
  import mdu_issue_scheduler_pkg::*;

  logic           valid;
  logic           advance;
  logic           mdu_use;
  logic           mdu_start;
  mdu_operation_t mdu_operation;
  logic           mdu_issue;
  logic           busy;
  logic           busy_is_div;
  logic           done;
  logic           stall_request;

  modport master (
    output valid, advance, mdu_use, mdu_start, mdu_operation,
    input  mdu_issue, busy, busy_is_div, done, stall_request
  );

  modport slave (
    input  valid, advance, mdu_use, mdu_start, mdu_operation,
    output mdu_issue, busy, busy_is_div, done, stall_request
  );
endinterface

// File: rtl/mdu_issue_scheduler.sv
// Issues one-shot starts to the multi-cycle MDU and stalls later MDU instructions
// while a multiply or divide is in flight; occupancy is tracked by a down-counter.
module mdu_issue_scheduler
  import mdu_issue_scheduler_pkg::*;
#(
  parameter int MUL_LATENCY = 5,
  parameter int DIV_LATENCY = 10,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  mdu_issue_scheduler_if.slave bus,
  output sched_state_t         state_dbg,
  output logic [CNT_WIDTH-1:0] cnt_dbg,
  output logic                 issued_dbg
);

  localparam logic [CNT_WIDTH-1:0] MUL_LOAD = CNT_WIDTH'(MUL_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] DIV_LOAD = CNT_WIDTH'(DIV_LATENCY - 1);

  sched_state_t         state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 issued, issued_next;
  logic                 done_next;
  logic                 busy;
  logic                 issue;
  logic                 start_is_div;

  assign busy         = (state != IDLE);
  assign start_is_div = (bus.mdu_operation == MDU_START_SIGNED_DIV) ||
                        (bus.mdu_operation == MDU_START_UNSIGNED_DIV);

  // Gated by reset so nothing escapes while the block is held in reset.
  assign issue = reset & bus.valid & bus.mdu_start & ~busy & ~issued;

  assign bus.mdu_issue     = issue;
  assign bus.busy          = busy;
  assign bus.busy_is_div   = (state == DIV_BUSY);
  assign bus.stall_request = reset & bus.valid & bus.mdu_use & busy & ~issued;

  assign state_dbg  = state;
  assign cnt_dbg    = cnt;
  assign issued_dbg = issued;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      issued   <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      issued   <= issued_next;
      bus.done <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    done_next   = 1'b0;
    issued_next = issued;

    // issued remembers that the instruction still sitting in E already started the MDU.
    if (bus.advance) begin
      issued_next = 1'b0;
    end else if (issue) begin
      issued_next = 1'b1;
    end

    case (state)
      IDLE: begin
        if (issue) begin
          if (start_is_div) begin
            state_next = DIV_BUSY;
            cnt_next   = DIV_LOAD;
          end else begin
            state_next = MUL_BUSY;
            cnt_next   = MUL_LOAD;
          end
        end
      end
      MUL_BUSY, DIV_BUSY: begin
        if (cnt == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mdu_issue_scheduler.sv
// Bench for mdu_issue_scheduler: directed scenarios plus random traffic against a
// reference model that tracks each operation as a window of busy cycle indices.
module tb_mdu_issue_scheduler;
  import mdu_issue_scheduler_pkg::*;

  localparam int MUL_L = 5;
  localparam int DIV_L = 10;

  logic         clock;
  logic         reset;
  sched_state_t state_dbg;
  logic [3:0]   cnt_dbg;
  logic         issued_dbg;

  mdu_issue_scheduler_if bus ();

  mdu_issue_scheduler #(
    .MUL_LATENCY(MUL_L),
    .DIV_LATENCY(DIV_L),
    .CNT_WIDTH  (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg),
    .cnt_dbg   (cnt_dbg),
    .issued_dbg(issued_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {mdu_issue, busy, busy_is_div, done, stall_request, issued}
  wire [5:0] obs = {bus.mdu_issue, bus.busy, bus.busy_is_div, bus.done,
                    bus.stall_request, issued_dbg};

  int n_checks;
  int n_fail;

  // reference model: op occupies cycles b_start..b_end, done in b_end+1
  int cyc;
  int b_start;
  int b_end;
  bit m_div;
  bit m_issued;

  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];

  function automatic bit op_is_div(mdu_operation_t op);
    return (op == MDU_START_SIGNED_DIV) || (op == MDU_START_UNSIGNED_DIV);
  endfunction

  function automatic logic [5:0] exp_vec();
    logic eb;
    eb = (cyc >= b_start) && (cyc <= b_end);
    return {bus.valid & bus.mdu_start & ~eb & ~m_issued, eb, eb & m_div,
            logic'(cyc == b_end + 1), bus.valid & bus.mdu_use & eb & ~m_issued, m_issued};
  endfunction

  task automatic model_reset();
    b_start  = -100;
    b_end    = -100;
    m_div    = 1'b0;
    m_issued = 1'b0;
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic a, input logic u, input logic s,
                       input mdu_operation_t op);
    bus.valid         = v;
    bus.advance       = a;
    bus.mdu_use       = u;
    bus.mdu_start     = s;
    bus.mdu_operation = op;
  endtask

  task automatic tick();
    logic [5:0] e;
    @(posedge clock);
    e = exp_vec();
    if (e[5]) begin
      b_start = cyc + 1;
      b_end   = cyc + (op_is_div(bus.mdu_operation) ? DIV_L : MUL_L);
      m_div   = op_is_div(bus.mdu_operation);
    end
    if (bus.advance) m_issued = 1'b0;
    else if (e[5]) m_issued = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, 0, 0, MDU_NONE);
      @(negedge clock);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL drain cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1, 1, 1, 1, MDU_START_SIGNED_MUL);
    #3;
    n_checks++;
    if ({bus.mdu_issue, bus.busy, bus.busy_is_div, bus.done, bus.stall_request} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=00000",
               {bus.mdu_issue, bus.busy, bus.busy_is_div, bus.done, bus.stall_request});
    end
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    drive(0, 1, 0, 0, MDU_NONE);
    reset = 1'b1;
    cyc   = 0;
    model_reset();
    #1;
    n_checks++;
    if (state_dbg !== IDLE || cnt_dbg !== 4'd0 || obs !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_release state=%0d cnt=%0d obs=%b exp=0/0/000000",
               state_dbg, cnt_dbg, obs);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_mult();
    logic [2:0] lit;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive(1, 1, 1, 1, MDU_START_SIGNED_MUL);
      else drive(0, 1, 0, 0, MDU_NONE);
      @(negedge clock);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL mult_model i=%0d got=%b exp=%b", i, obs, exp_vec());
      end
      lit = {logic'(i == 0), logic'(i >= 1 && i <= 5), logic'(i == 6)};
      n_checks++;
      if ({bus.mdu_issue, bus.busy, bus.done} !== lit || bus.busy_is_div !== 1'b0) begin
        n_fail++;
        $display("FAIL mult_timing i=%0d issue/busy/done=%b exp=%b div=%b", i,
                 {bus.mdu_issue, bus.busy, bus.done}, lit, bus.busy_is_div);
      end
      tick();
    end
  endtask

  task automatic test_div_stall();
    int stalls;
    int issues;
    stalls = 0;
    issues = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) drive(1, 1, 1, 1, MDU_START_SIGNED_DIV);
      else drive(1, logic'(i == 11), 1, 0, MDU_MFLO);
      @(negedge clock);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL div_model i=%0d got=%b exp=%b", i, obs, exp_vec());
      end
      if (i >= 1) begin
        stalls += int'(bus.stall_request);
        issues += int'(bus.mdu_issue);
      end
      if (i == 11) begin
        n_checks++;
        if (bus.done !== 1'b1 || bus.stall_request !== 1'b0) begin
          n_fail++;
          $display("FAIL div_release done=%b stall=%b exp=1/0", bus.done, bus.stall_request);
        end
      end
      tick();
    end
    n_checks++;
    if (stalls != 10 || issues != 0) begin
      n_fail++;
      $display("FAIL div_counts stalls=%0d issues=%0d exp=10/0", stalls, issues);
    end
  endtask

  task automatic test_issue_hold();
    int stalls;
    int issues;
    stalls = 0;
    issues = 0;
    for (int i = 0; i < 8; i++) begin
      if (i <= 3) drive(1, logic'(i == 3), 1, 1, MDU_START_UNSIGNED_MUL);
      else drive(0, 1, 0, 0, MDU_NONE);
      @(negedge clock);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL hold_model i=%0d got=%b exp=%b", i, obs, exp_vec());
      end
      stalls += int'(bus.stall_request);
      issues += int'(bus.mdu_issue);
      if (i >= 1 && i <= 4) begin
        n_checks++;
        if (issued_dbg !== logic'(i <= 3)) begin
          n_fail++;
          $display("FAIL hold_issued i=%0d got=%b exp=%b", i, issued_dbg, logic'(i <= 3));
        end
      end
      tick();
    end
    n_checks++;
    if (stalls != 0 || issues != 1) begin
      n_fail++;
      $display("FAIL hold_counts stalls=%0d issues=%0d exp=0/1", stalls, issues);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] lit;
    for (int i = 0; i < 13; i++) begin
      if (i == 0 || i == 6) drive(1, 1, 1, 1, MDU_START_SIGNED_MUL);
      else if (i <= 5) drive(1, 0, 1, 1, MDU_START_SIGNED_MUL);
      else drive(0, 1, 0, 0, MDU_NONE);
      @(negedge clock);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b_model i=%0d got=%b exp=%b", i, obs, exp_vec());
      end
      lit = {logic'(i == 0 || i == 6), logic'(i >= 1 && i <= 5),
             logic'((i >= 1 && i <= 5) || (i >= 7 && i <= 11)), logic'(i == 6 || i == 12)};
      n_checks++;
      if ({bus.mdu_issue, bus.stall_request, bus.busy, bus.done} !== lit) begin
        n_fail++;
        $display("FAIL b2b_timing i=%0d issue/stall/busy/done=%b exp=%b", i,
                 {bus.mdu_issue, bus.stall_request, bus.busy, bus.done}, lit);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1, 1, 1, 1, MDU_START_UNSIGNED_DIV);
      else drive(0, 1, 0, 0, MDU_NONE);
      @(negedge clock);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL areset_model i=%0d got=%b exp=%b", i, obs, exp_vec());
      end
      tick();
    end
    drive(1, 0, 1, 1, MDU_START_SIGNED_DIV);
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 6'b0 || cnt_dbg !== 4'd0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL areset_clear obs=%b cnt=%0d state=%0d exp=000000/0/0",
               obs, cnt_dbg, state_dbg);
    end
    #1 reset = 1'b1;
    model_reset();
    drive(1, 1, 1, 0, MDU_MTHI);
    @(negedge clock);
    n_checks++;
    if (bus.stall_request !== 1'b0 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL areset_mthi stall=%b got=%b exp=%b", bus.stall_request, obs, exp_vec());
    end
    tick();
  endtask

  task automatic test_bubble();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 1, MDU_START_SIGNED_DIV);
      @(negedge clock);
      n_checks++;
      if (bus.mdu_issue !== 1'b0 || bus.stall_request !== 1'b0 || state_dbg !== IDLE) begin
        n_fail++;
        $display("FAIL bubble i=%0d issue=%b stall=%b state=%0d exp=0/0/0", i,
                 bus.mdu_issue, bus.stall_request, state_dbg);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic v;
    logic u;
    for (int i = 0; i < 400; i++) begin
      v = logic'($urandom_range(0, 3) != 0);
      u = logic'($urandom_range(0, 1));
      drive(v, logic'($urandom_range(0, 1)), u, u & logic'($urandom_range(0, 1)),
            mdu_operation_t'($urandom_range(0, 8)));
      @(negedge clock);
      exp_q.push_back(exp_vec());
      obs_q.push_back(obs);
      tick();
    end
    // scoreboard
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [5:0] e;
      logic [5:0] o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random idx=%0d got=%b exp=%b", i, o, e);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    model_reset();
    test_reset();
    test_mult();
    test_div_stall();
    test_issue_hold();
    test_back_to_back();
    test_async_reset();
    drain(2);
    test_bubble();
    test_random();
    drain(12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
